// File: rtl/hsv_pwm_bank.sv
// rtl/hsv_pwm_bank.sv - multi-channel PWM bank, shared period counter, double-buffered levels
// Optional feature: define HSV_PWM_FADE_EN to step active levels 1 LSB per period toward pending.
module hsv_pwm_bank #(
  parameter int WIDTH = 8,
  parameter int CHANNELS = 3,
  parameter logic [CHANNELS-1:0] INVERT_MASK = '0,
  localparam int AW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic [WIDTH-1:0]    top,
  input  logic                wr_en,
  input  logic [AW-1:0]       wr_addr,
  input  logic [WIDTH-1:0]    wr_data,
  output logic [CHANNELS-1:0] out,
  output logic                period_tick
);

  localparam logic [AW:0] CH_LIMIT = (AW+1)'(CHANNELS);

  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] top_act;
  logic [WIDTH-1:0] pending [CHANNELS];
  logic [WIDTH-1:0] active  [CHANNELS];
  logic             wrap;
  logic             wr_ok;

  assign wrap  = enable && (count == top_act);
  assign wr_ok = wr_en && ({1'b0, wr_addr} < CH_LIMIT);

`ifdef HSV_PWM_FADE_EN
  function automatic logic [WIDTH-1:0] fade_step(input logic [WIDTH-1:0] cur,
                                                 input logic [WIDTH-1:0] tgt);
    if (cur < tgt)      return cur + WIDTH'(1);
    else if (cur > tgt) return cur - WIDTH'(1);
    else                return cur;
  endfunction
`endif

  // Shared period counter: runs 0..top_act while enabled, parked at 0 when idle
  always_ff @(posedge clk) begin
    if (reset)                count <= '0;
    else if (!enable || wrap) count <= '0;
    else                      count <= count + WIDTH'(1);
  end

  // Period length is latched at wrap so a lowered top can never strand the counter
  always_ff @(posedge clk) begin
    if (reset)                top_act <= '0;
    else if (!enable || wrap) top_act <= top;
  end

  // Pending level writes; out-of-range channel indices are dropped
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int ch = 0; ch < CHANNELS; ch++) pending[ch] <= '0;
    end else if (wr_ok) begin
      pending[wr_addr] <= wr_data;
    end
  end

  // Active levels follow pending directly when idle, otherwise only at wrap
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int ch = 0; ch < CHANNELS; ch++) active[ch] <= '0;
    end else if (!enable) begin
      for (int ch = 0; ch < CHANNELS; ch++) active[ch] <= pending[ch];
    end else if (wrap) begin
      for (int ch = 0; ch < CHANNELS; ch++) begin
`ifdef HSV_PWM_FADE_EN
        active[ch] <= fade_step(active[ch], pending[ch]);
`else
        active[ch] <= pending[ch];
`endif
      end
    end
  end

  // Tick marks the first cycle of every period
  always_ff @(posedge clk) begin
    if (reset) period_tick <= 1'b0;
    else       period_tick <= wrap;
  end

  // PWM outputs: registered compare of the counter against each active level
  always_ff @(posedge clk) begin
    if (reset) begin
      out <= '0;
    end else begin
      for (int ch = 0; ch < CHANNELS; ch++) begin
        out[ch] <= enable ? ((count < active[ch]) ^ INVERT_MASK[ch]) : INVERT_MASK[ch];
      end
    end
  end

endmodule

// File: tb/tb_hsv_pwm_bank.sv
// tb/tb_hsv_pwm_bank.sv - self-checking bench for hsv_pwm_bank with a cycle-level reference model
module tb_hsv_pwm_bank;
  localparam logic [2:0] INV = 3'b100;

  logic       clk = 1'b0;
  logic       reset, enable, wr_en;
  logic [7:0] top, wr_data;
  logic [1:0] wr_addr;
  logic [2:0] out;
  logic       period_tick;

  int vectors = 0;
  int miscompares = 0;

  hsv_pwm_bank #(.WIDTH(8), .CHANNELS(3), .INVERT_MASK(INV)) dut (
    .clk(clk), .reset(reset), .enable(enable), .top(top),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .out(out), .period_tick(period_tick)
  );

  always #5 clk = ~clk;

  // Reference model: period position, period length and per-channel levels as integers
  int       m_pos, m_len_m1;
  int       m_pend [3];
  int       m_act  [3];
  logic [2:0] exp_out;
  logic     exp_tick;
  bit       m_end;
  bit       model_ok = 0;

  always @(posedge clk) begin
    model_ok <= 1;
    if (reset) begin
      m_pos = 0; m_len_m1 = 0; exp_out = 3'b000; exp_tick = 0;
      for (int c = 0; c < 3; c++) begin m_pend[c] = 0; m_act[c] = 0; end
    end else begin
      m_end = enable && (m_pos == m_len_m1);
      for (int c = 0; c < 3; c++)
        exp_out[c] = enable ? ((m_pos < m_act[c]) ^ INV[c]) : INV[c];
      exp_tick = m_end;
      if (!enable || m_end) begin
        m_pos = 0;
        m_len_m1 = int'(top);
        for (int c = 0; c < 3; c++) begin
`ifdef HSV_PWM_FADE_EN
          if (enable) m_act[c] += (m_pend[c] > m_act[c]) ? 1 : ((m_pend[c] < m_act[c]) ? -1 : 0);
          else        m_act[c] = m_pend[c];
`else
          m_act[c] = m_pend[c];
`endif
        end
      end else begin
        m_pos++;
      end
      if (wr_en && wr_addr < 2'd3) m_pend[wr_addr] = int'(wr_data);
    end
  end

  // Cycle-by-cycle comparison against the model
  always @(negedge clk) begin
    if (model_ok) begin
      vectors++;
      if (out !== exp_out || period_tick !== exp_tick) begin
        miscompares++;
        $display("FAIL cycle_check t=%0t: out=%b tick=%b, expected out=%b tick=%b",
                 $time, out, period_tick, exp_out, exp_tick);
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic write(input int ch, input int data);
    wr_en = 1'b1; wr_addr = 2'(ch); wr_data = 8'(data);
    step();
    wr_en = 1'b0;
  endtask

  task automatic next_tick();
    int n;
    n = 0;
    do begin step(); n++; end while (!period_tick && n < 500);
    if (!period_tick) check("tick_timeout", 0, 1);
  endtask

  // Called on a tick cycle; counts high cycles of one channel up to and including the next tick
  task automatic measure(input int ch, output int highs, output int len);
    highs = 0; len = 0;
    do begin
      step(); len++;
      highs += int'(out[ch]);
    end while (!period_tick && len < 500);
    if (!period_tick) check("measure_timeout", 0, 1);
  endtask

  int h, l;
`ifdef HSV_PWM_FADE_EN
  int fade_exp [5] = '{1, 2, 3, 4, 4};
`else
  int fade_exp [5] = '{4, 4, 4, 4, 4};
`endif

  initial begin
    reset = 1; enable = 1; top = 8'd9; wr_en = 0; wr_addr = 0; wr_data = 0;
    repeat (3) step();
    check("reset_out", int'(out), 0);
    check("reset_tick", int'(period_tick), 0);

    // Basic duty: levels loaded while idle take effect directly
    reset = 0; enable = 0;
    write(0, 3); write(1, 5); write(2, 3);
    enable = 1;
    next_tick();
    measure(0, h, l);
    check("ch0_duty3_high", h, 3);
    check("period_len10", l, 10);
    measure(2, h, l);
    check("ch2_inverted_high", h, 7);

    // Level extremes on ch1
    write(1, 0);   next_tick(); next_tick(); measure(1, h, l);
    check("ch1_level0", h, 0);
    write(1, 10);  next_tick(); next_tick(); measure(1, h, l);
    check("ch1_level10", h, 10);
    write(1, 255); next_tick(); next_tick(); measure(1, h, l);
    check("ch1_level255", h, 10);

    // Mid-period write applies at the next period
    write(1, 5); next_tick(); next_tick();
    h = 0;
    for (int i = 1; i <= 10; i++) begin
      step();
      h += int'(out[1]);
      if (i == 4) begin wr_en = 1; wr_addr = 2'd1; wr_data = 8'd7; end
      if (i == 5) wr_en = 0;
    end
    check("midwrite_cur_period", h, 5);
    check("midwrite_tick", int'(period_tick), 1);
    // Write landing in the wrap cycle applies one period later
    h = 0;
    for (int i = 1; i <= 10; i++) begin
      step();
      h += int'(out[1]);
      if (i == 9) begin wr_en = 1; wr_addr = 2'd1; wr_data = 8'd2; end
      if (i == 10) wr_en = 0;
    end
    check("midwrite_next_period", h, 7);
    measure(1, h, l);
    check("wrapwrite_old_value", h, 7);
    measure(1, h, l);
    check("wrapwrite_new_value", h, 2);

    // Idle level, reset level, ignored out-of-range address
    enable = 0; step(); step();
    check("idle_out", int'(out), 4);
    reset = 1; step();
    check("reset_mid_out", int'(out), 0);
    reset = 0;
    write(0, 4); write(3, 9);
    enable = 1;
    next_tick();
    measure(0, h, l); check("after_reset_ch0", h, 4);
    measure(1, h, l); check("addr3_ignored_ch1", h, 0);
    measure(2, h, l); check("after_reset_ch2", h, 10);

    // top=0: single-cycle period
    top = 8'd0; next_tick(); next_tick();
    measure(0, h, l);
    check("top0_len", l, 1);
    check("top0_high", h, 1);

    // Fade (or direct load without the fade feature)
    enable = 0; top = 8'd3; write(0, 0); step();
    enable = 1;
    write(0, 4);
    next_tick();
    for (int p = 0; p < 5; p++) begin
      measure(0, h, l);
      check($sformatf("fade_period%0d", p), h, fade_exp[p]);
    end

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      reset   = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 49) == 0) enable = ~enable;
      if ($urandom_range(0, 19) == 0) top = 8'($urandom_range(0, 12));
      wr_en   = ($urandom_range(0, 2) == 0);
      wr_addr = 2'($urandom_range(0, 3));
      wr_data = 8'($urandom_range(0, 14));
      step();
    end
    reset = 0; wr_en = 0; enable = 1;
    repeat (20) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
